bram_stream_reader: RTL

Read-side companion to the accelerator's simple dual-port block RAM: walks a contiguous address range of the RAM read port and streams each word out over a valid/ready interface at one word per cycle. Sits between a BRAM instance (written by the producer side) and the downstream OT datapath consumer. Software/control logic issues `start` with a base address and word count, then waits for `done`.

---
 rtl/bram_stream_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Walks a contiguous address range of a block RAM read port and streams
//   each word out at up to one word per cycle.
//
//   Output handshake: a word moves from out_data to the consumer on a rising
//   clk edge where out_valid and out_ready are both high. Once out_valid is
//   raised, out_data and out_last stay unchanged until that edge; out_valid
//   never drops without an accept, except on abort or reset.
//
//   RAM read data is combinational from rd_addr. The word is registered into
//   out_data on the same edge that advances rd_addr. A RAM write landing on
//   that edge therefore leaves the old word in out_data.
//
//   Optional build macro:
//     BRAM_READER_REVERSE_EN - the address decrements from base_addr instead
//                              of incrementing (modulo the RAM depth).
//
//   Controller state is visible on busy, which is high whenever the
//   controller is not in IDLE.

module bram_stream_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   remaining_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_nxt;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic                  out_valid_nxt;
    logic                  out_last_nxt;
    logic                  done_nxt;
    logic                  streaming;
    logic                  accept;
    logic                  load;

    // Address that follows the current read address in streaming order.
`ifdef BRAM_READER_REVERSE_EN
    assign addr_step = rd_addr - ADDR_ONE;
`else
    assign addr_step = rd_addr + ADDR_ONE;
`endif

    assign streaming = (state == ST_STREAM);

    // The consumer takes the current word on this edge.
    assign accept = streaming && out_valid && out_ready;

    // The output register is empty or is being emptied, and words remain to
    // fetch. The load and the accept can share an edge, which keeps the
    // stream free of bubbles.
    assign load = streaming && (remaining != REM_ZERO) && (!out_valid || out_ready);

    assign busy = streaming;

    // Next-state and datapath decisions; abort overrides everything but reset.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        rd_addr_nxt   = rd_addr;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        done_nxt      = 1'b0;

        if (abort) begin
            // Drop the pending word and any unread words. rd_addr is left
            // where it stopped, and no completion is reported.
            state_nxt     = ST_IDLE;
            remaining_nxt = REM_ZERO;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length != REM_ZERO) begin
                            rd_addr_nxt   = base_addr;
                            remaining_nxt = length;
                            state_nxt     = ST_STREAM;
                        end else begin
                            // An empty transfer completes at once, without beats.
                            done_nxt = 1'b1;
                        end
                    end
                end

                ST_STREAM: begin
                    if (load) begin
                        out_data_nxt  = rd_data;
                        out_valid_nxt = 1'b1;
                        out_last_nxt  = (remaining == REM_ONE);
                        rd_addr_nxt   = addr_step;
                        remaining_nxt = remaining - REM_ONE;
                    end else if (accept) begin
                        // Only reachable with nothing left to fetch, so this
                        // accept takes the final word.
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        done_nxt      = 1'b1;
                        state_nxt     = ST_IDLE;
                    end
                end

                default: begin
                    state_nxt     = ST_IDLE;
                    remaining_nxt = REM_ZERO;
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= REM_ZERO;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            rd_addr   <= rd_addr_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            done      <= done_nxt;
        end
    end

endmodule
